lock_supervisor: RTL
====================

// Module: lock_supervisor
// PURPOSE
//  Automatic acquire/relock sequencer for the lock controller.
//  - Arms the ramp sweep and the lock trigger search.
//  - Waits for the lock trigger pulse, then lets the PIDs settle.
//  - Monitors the error signal. If lock is lost, it drops the PIDs and retries up to a limit.
//  - Outputs drive the launch/enable-control fields of the lock_ctrl word in the lock top level.
// PARAMETERS
//  TW    32  width of settle/unlock/timeout timers and their thresholds
//  RW     4  width of retry counter and max_retry
// PORTS
//  clk           in   1   system clock
//  rstn          in   1   asynchronous reset, active low
//  enable        in   1   level; 1 = supervise, 0 = force IDLE
//  lock_trig     in   1   1-cycle pulse from lock controller trigger (lock_ctrl_trig)
//  err           in  14   signed error signal monitored while locked
//  err_window    in  13   unsigned |err| limit; |err| > err_window = out of window
//  settle_time   in  TW   cycles spent in SETTLE
//  unlock_time   in  TW   consecutive out-of-window cycles that declare loss of lock
//  trig_timeout  in  TW   max cycles in SWEEP waiting for lock_trig; 0 = no timeout
//  max_retry     in  RW   retries allowed before FAIL
//  launch_lock   out  1   arm trigger search (lock_ctrl bit 1)
//  ramp_enable   out  1   ramp enable control (lock_ctrl bit 4)
//  pidA_enable   out  1   PID A enable control (lock_ctrl bit 3)
//  pidB_enable   out  1   PID B enable control (lock_ctrl bit 2)
//  locked        out  1   1 while in LOCKED
//  failed        out  1   1 while in FAIL
//  retry_cnt     out  RW  retries consumed since IDLE
//  state         out  3   current state encoding, for register readback
// BEHAVIOUR
//  Reset
//  - rstn low: state=IDLE, retry_cnt=0, timer=0, oob_cnt=0, all outputs 0, asynchronously.
//
//  Outputs
//  - All outputs are registered, Moore decode of state.
//  - Outputs reflect the new state in the cycle after the state register updates.
//
//  States (encoding)
//  - IDLE(0)
//    - All enables 0; retry_cnt cleared.
//    - enable=1 -> SWEEP.
//  - SWEEP(1)
//    - Outputs: launch_lock=1, ramp_enable=1, pidA_enable=pidB_enable=0.
//    - timer counts up from 0.
//    - lock_trig=1 -> SETTLE.
//    - Else if trig_timeout!=0 and timer==trig_timeout-1 -> RETRY.
//    - If lock_trig and timeout occur in the same cycle, lock_trig wins.
//  - SETTLE(2)
//    - Outputs: ramp_enable=0, pidA_enable=pidB_enable=1, launch_lock=0.
//    - err is ignored.
//    - Leaves when timer>=settle_time -> LOCKED; settle_time=0 gives 1 cycle.
//  - LOCKED(3)
//    - Outputs: same enables as SETTLE, plus locked=1.
//    - oob_cnt increments on each out-of-window cycle and clears on any in-window cycle.
//    - oob_cnt saturates at all-ones.
//    - oob_cnt reaching max(unlock_time,1) -> RETRY.
//  - RETRY(4), 1 cycle
//    - All enables 0.
//    - If retry_cnt>=max_retry -> FAIL.
//    - Else retry_cnt+=1 (saturating) -> SWEEP.
//  - FAIL(5)
//    - Outputs: all enables 0, failed=1.
//    - Holds until enable=0.
//  - enable=0 in any state -> IDLE on the next clock; this has priority over every other transition.
//
//  Timers and arithmetic
//  - timer and oob_cnt clear on every state change.
//  - |err| is computed in 15 bits unsigned: -8192 -> 8192, no saturation.
//    - With err_window max 8191, err=-8192 is always out of window.
//  - Counter widths: TW bits, unsigned compare.
//  - retry_cnt is not cleared by a successful LOCKED; it is cleared only in IDLE.
// TESTING
//  1. Reset, enable=1, lock_trig pulse at cycle 50, settle_time=100
//     -> SWEEP outputs (launch=1, ramp=1) until trig;
//     -> SETTLE for 101 cycles;
//     -> locked=1 with pidA=pidB=1, ramp=0.
//  2. Locked, err_window=100, err=101 for 9 cycles then 0, unlock_time=10
//     -> stays LOCKED.
//     Then err=-101 for 10 cycles -> RETRY, retry_cnt=1, back in SWEEP.
//  3. trig_timeout=20, max_retry=2, no lock_trig
//     -> SWEEP three times (retry_cnt 0,1,2);
//     -> then FAIL with failed=1, all enables 0;
//     -> enable=0 -> IDLE, retry_cnt=0.
//  4. lock_trig asserted on the exact timeout cycle
//     -> SETTLE entered, retry_cnt unchanged.
//  5. Drop rstn mid-SETTLE
//     -> outputs 0 immediately.
//     Release rstn with enable=1 -> IDLE then SWEEP on the next clock.
//  6. err=-8192, err_window=8191 while LOCKED -> counted out of window.
//     enable=0 in LOCKED -> IDLE in one cycle, pids off.

Source files
------------

// File: rtl/lock_supervisor.sv
// Acquire/relock sequencer: sweeps for a lock trigger, settles the PIDs, watches the
// error signal while locked and retries a bounded number of times before giving up.
module lock_supervisor #(
  parameter int TW = 32,
  parameter int RW = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 lock_trig,
  input  logic signed [13:0]   err,
  input  logic        [12:0]   err_window,
  input  logic        [TW-1:0] settle_time,
  input  logic        [TW-1:0] unlock_time,
  input  logic        [TW-1:0] trig_timeout,
  input  logic        [RW-1:0] max_retry,
  output logic                 launch_lock,
  output logic                 ramp_enable,
  output logic                 pidA_enable,
  output logic                 pidB_enable,
  output logic                 locked,
  output logic                 failed,
  output logic        [RW-1:0] retry_cnt,
  output logic        [2:0]    state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SWEEP  = 3'd1,
    SETTLE = 3'd2,
    LOCKED = 3'd3,
    RETRY  = 3'd4,
    FAIL   = 3'd5
  } state_t;

  state_t        cur;
  state_t        nxt;
  logic [TW-1:0] timer;
  logic [TW-1:0] oob_cnt;
  logic [TW-1:0] timer_inc;
  logic [TW-1:0] oob_next;
  logic [TW-1:0] unlock_thr;
  logic [14:0]   err_ext;
  logic [14:0]   err_abs;
  logic          out_of_window;
  logic          timeout_hit;

  // |err| widened to 15 bits so that -8192 maps to +8192 without saturating
  assign err_ext       = {err[13], err};
  assign err_abs       = err[13] ? ((~err_ext) + 15'd1) : err_ext;
  assign out_of_window = err_abs > {2'b00, err_window};

  assign timer_inc   = (timer == '1) ? timer : timer + TW'(1);
  assign oob_next    = !out_of_window ? '0 :
                       (oob_cnt == '1) ? oob_cnt : oob_cnt + TW'(1);
  assign unlock_thr  = (unlock_time == '0) ? TW'(1) : unlock_time;
  assign timeout_hit = (trig_timeout != '0) && (timer == trig_timeout - TW'(1));

  always_comb begin
    nxt = cur;
    if (!enable) begin
      nxt = IDLE;
    end else begin
      case (cur)
        IDLE:   nxt = SWEEP;
        SWEEP:  begin
          // A trigger on the timeout cycle still counts as an acquisition
          if (lock_trig)        nxt = SETTLE;
          else if (timeout_hit) nxt = RETRY;
        end
        SETTLE: if (timer >= settle_time) nxt = LOCKED;
        LOCKED: if (oob_next >= unlock_thr) nxt = RETRY;
        RETRY:  nxt = (retry_cnt >= max_retry) ? FAIL : SWEEP;
        FAIL:   nxt = FAIL;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur         <= IDLE;
      timer       <= '0;
      oob_cnt     <= '0;
      retry_cnt   <= '0;
      launch_lock <= 1'b0;
      ramp_enable <= 1'b0;
      pidA_enable <= 1'b0;
      pidB_enable <= 1'b0;
      locked      <= 1'b0;
      failed      <= 1'b0;
    end else begin
      cur <= nxt;

      if (nxt != cur) begin
        timer   <= '0;
        oob_cnt <= '0;
      end else begin
        timer   <= timer_inc;
        oob_cnt <= (cur == LOCKED) ? oob_next : '0;
      end

      // Retries accumulate across successful locks; only a return to IDLE clears them
      if (cur == IDLE || nxt == IDLE) begin
        retry_cnt <= '0;
      end else if (cur == RETRY && nxt == SWEEP && retry_cnt != '1) begin
        retry_cnt <= retry_cnt + RW'(1);
      end

      launch_lock <= 1'b0;
      ramp_enable <= 1'b0;
      pidA_enable <= 1'b0;
      pidB_enable <= 1'b0;
      locked      <= 1'b0;
      failed      <= 1'b0;
      case (cur)
        SWEEP: begin
          launch_lock <= 1'b1;
          ramp_enable <= 1'b1;
        end
        SETTLE: begin
          pidA_enable <= 1'b1;
          pidB_enable <= 1'b1;
        end
        LOCKED: begin
          pidA_enable <= 1'b1;
          pidB_enable <= 1'b1;
          locked      <= 1'b1;
        end
        FAIL:    failed <= 1'b1;
        default: ;
      endcase
    end
  end

  assign state = cur;

endmodule
